// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the runtime clock-divider controller.
package clk_div_pkg;

  typedef enum logic [1:0] {
    STOP   = 2'd0,
    RUN    = 2'd1,
    SWITCH = 2'd2
  } state_e;

  localparam int unsigned MIN_DIV   = 2;
  localparam int unsigned STOP_CODE = 0;

  function automatic logic div_legal(input int unsigned div, input int unsigned max);
    return (div >= MIN_DIV) && (div <= max);
  endfunction

endpackage

// File: rtl/mod_n_counter.sv
// Mod-N counter: synchronous load of a new ratio restarts the count at 0;
// tc flags the last count (N-1) of the current period.
module mod_n_counter #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [DIV_W-1:0] load_n,
  output logic [DIV_W-1:0] cnt,
  output logic             tc
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] n_q, n_d;

  // A zero ratio means stopped; it must never look like a terminal count.
  assign tc  = (n_q != '0) && (cnt_q == n_q - DIV_W'(1));
  assign cnt = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    n_d   = n_q;
    if (load) begin
      cnt_d = '0;
      n_d   = load_n;
    end else if (en) begin
      cnt_d = tc ? '0 : cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      n_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      n_q   <= n_d;
    end
  end

endmodule

// File: rtl/clk_div_sequencer.sv
// Runtime controller for the mod-N clock divider: accepts ratio/stop commands
// and applies them only on period boundaries so clk_out never shows a runt.
module clk_div_sequencer
  import clk_div_pkg::*;
#(
  parameter int DIV_W   = 8,
  parameter int MAX_DIV = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             period_tick,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cur_q, cur_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic             err_q, err_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;

  logic             hs, legal, stop_req, en, load, apply, running_d;
  logic [DIV_W-1:0] load_n, apply_v, cnt, cnt_nxt;
  logic             tc;

  assign cfg_ready = (state_q != SWITCH);
  assign busy      = (state_q != STOP);
  assign en        = (state_q != STOP);
  assign hs        = cfg_valid & cfg_ready;
  assign legal     = div_legal(32'(cfg_div), MAX_DIV);
  assign stop_req  = (cfg_div == DIV_W'(STOP_CODE));

  mod_n_counter #(.DIV_W(DIV_W)) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .load   (load),
    .load_n (load_n),
    .cnt    (cnt),
    .tc     (tc)
  );

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    pend_d  = pend_q;
    load    = 1'b0;
    load_n  = cur_q;
    apply   = 1'b0;
    apply_v = '0;
    err_d   = hs & ~legal & ~stop_req;

    case (state_q)
      STOP: begin
        if (hs && legal) begin
          load    = 1'b1;
          load_n  = cfg_div;
          cur_d   = cfg_div;
          state_d = RUN;
        end
      end
      RUN: begin
        if (hs && (legal || stop_req)) begin
          // On the last count the command lands on the boundary right away.
          if (tc) begin
            apply   = 1'b1;
            apply_v = cfg_div;
          end else begin
            pend_d  = cfg_div;
            state_d = SWITCH;
          end
        end
      end
      SWITCH: begin
        if (tc) begin
          apply   = 1'b1;
          apply_v = pend_q;
          pend_d  = '0;
        end
      end
      default: state_d = STOP;
    endcase

    // Stop is applied as a zero ratio, which also parks the counter at 0.
    if (apply) begin
      load    = 1'b1;
      load_n  = apply_v;
      cur_d   = apply_v;
      state_d = (apply_v == DIV_W'(STOP_CODE)) ? STOP : RUN;
    end

    // Outputs are registered from the count that will hold after this edge,
    // keeping clk_out/period_tick aligned with cnt.
    cnt_nxt   = load ? '0 : (en ? (tc ? '0 : cnt + DIV_W'(1)) : cnt);
    running_d = (state_d != STOP);
    clk_out_d = running_d && (cnt_nxt < (cur_d >> 1));
    tick_d    = running_d && (cnt_nxt == cur_d - DIV_W'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= STOP;
      cur_q     <= '0;
      pend_q    <= '0;
      err_q     <= 1'b0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      pend_q    <= pend_d;
      err_q     <= err_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign cfg_err     = err_q;
  assign clk_out     = clk_out_q;
  assign period_tick = tick_q;

endmodule

// File: tb/tb_clk_div_sequencer.sv
// Bench for clk_div_sequencer: period-level reference model checked every
// cycle, plus directed scenarios with literal expected waveforms.
module tb_clk_div_sequencer;

  localparam int DIV_W   = 8;
  localparam int MAX_DIV = 200;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_valid = 1'b0;
  logic [DIV_W-1:0] cfg_div = '0;
  logic             cfg_ready, cfg_err, clk_out, period_tick, busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  clk_div_sequencer #(.DIV_W(DIV_W), .MAX_DIV(MAX_DIV)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_div     (cfg_div),
    .cfg_err     (cfg_err),
    .clk_out     (clk_out),
    .period_tick (period_tick),
    .busy        (busy)
  );

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0b expected=%0b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chkv(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: ratio (0 = stopped), phase within the current period,
  // and at most one pending command.
  int m_ratio = 0, m_phase = 0, m_pval = 0;
  bit m_pend = 0, m_err = 0, m_on = 0;

  always @(posedge clk) begin : model
    int d;
    bit hs, lgl, stopc, cmd;
    if (rst) begin
      m_ratio = 0; m_phase = 0; m_pend = 0; m_pval = 0; m_err = 0; m_on = 1;
    end else if (m_on) begin
      d     = int'(cfg_div);
      hs    = cfg_valid && !m_pend;
      lgl   = (d >= 2) && (d <= MAX_DIV);
      stopc = (d == 0);
      cmd   = hs && (lgl || stopc);
      m_err = hs && !lgl && !stopc;
      if (m_ratio == 0) begin
        if (cmd && lgl) begin
          m_ratio = d;
          m_phase = 0;
        end
      end else begin
        if (cmd) begin
          m_pend = 1;
          m_pval = d;
        end
        if (m_phase == m_ratio - 1) begin
          if (m_pend) begin
            m_ratio = m_pval;
            m_pend  = 0;
          end
          m_phase = 0;
        end else begin
          m_phase++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      chk("clk_out", clk_out, (m_ratio != 0) && (m_phase < m_ratio / 2));
      chk("period_tick", period_tick, (m_ratio != 0) && (m_phase == m_ratio - 1));
      chk("busy", busy, m_ratio != 0);
      chk("cfg_ready", cfg_ready, !m_pend);
      chk("cfg_err", cfg_err, m_err);
    end
  end

  task automatic drive(input logic v, input logic [DIV_W-1:0] d);
    cfg_valid = v;
    cfg_div   = d;
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] cb, tb, bb;
    int          hi, rlow;

    // Reset state
    rst = 1'b1;
    repeat (3) edge1();
    chk("rst_ready", cfg_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_clk_out", clk_out, 1'b0);
    chk("rst_tick", period_tick, 1'b0);
    chk("rst_err", cfg_err, 1'b0);
    rst = 1'b0;

    // Idle after reset release
    hi = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      hi += int'(clk_out) + int'(busy) + int'(!cfg_ready);
    end
    chkv("idle_activity", 32'(hi), 32'd0);

    // Load N=4 from STOP
    drive(1'b1, 8'd4);
    edge1();
    drive(1'b0, 8'd0);
    cb = '0; tb = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      cb = {cb[30:0], clk_out};
      tb = {tb[30:0], period_tick};
    end
    chkv("n4_clk_pattern", cb, 32'b11001100);
    chkv("n4_tick_pattern", tb, 32'b00010001);

    // Now at cnt==3: switch to N=2 with no SWITCH dwell
    drive(1'b1, 8'd2);
    edge1();
    drive(1'b0, 8'd0);
    chk("n2_no_switch_ready", cfg_ready, 1'b1);
    cb = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      cb = {cb[30:0], clk_out};
    end
    chkv("n2_clk_pattern", cb, 32'b101010);

    // N=3, then N=6 issued at cnt=0
    rst = 1'b1;
    edge1();
    rst = 1'b0;
    drive(1'b1, 8'd3);
    edge1();
    drive(1'b1, 8'd6);
    @(negedge clk);
    cb = {31'd0, clk_out};
    rlow = int'(!cfg_ready);
    edge1();
    drive(1'b0, 8'd0);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      cb = {cb[30:0], clk_out};
      rlow += int'(!cfg_ready);
    end
    chkv("n3_to_n6_clk", cb, 32'b100111000111000);
    chkv("n3_to_n6_ready_low", 32'(rlow), 32'd2);

    // N=5 with illegal commands, then stop
    rst = 1'b1;
    edge1();
    rst = 1'b0;
    drive(1'b1, 8'd5);
    edge1();
    drive(1'b1, 8'd1);
    edge1();
    chk("err_div1", cfg_err, 1'b1);
    chk("err_div1_busy", busy, 1'b1);
    drive(1'b1, 8'd201);
    edge1();
    chk("err_div_over_max", cfg_err, 1'b1);
    drive(1'b1, 8'd0);
    edge1();
    drive(1'b0, 8'd0);
    chk("stop_no_err", cfg_err, 1'b0);
    chk("stop_switch_ready", cfg_ready, 1'b0);
    cb = '0; tb = '0; bb = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cb = {cb[30:0], clk_out};
      tb = {tb[30:0], period_tick};
      bb = {bb[30:0], busy};
    end
    chkv("stop_clk", cb, 32'b0000);
    chkv("stop_tick", tb, 32'b0100);
    chkv("stop_busy", bb, 32'b1100);

    // Reset during SWITCH with N=8 pending
    drive(1'b1, 8'd3);
    edge1();
    drive(1'b1, 8'd8);
    edge1();
    drive(1'b0, 8'd0);
    chk("pre_rst_switch", cfg_ready, 1'b0);
    rst = 1'b1;
    edge1();
    rst = 1'b0;
    chk("midrst_clk_out", clk_out, 1'b0);
    chk("midrst_tick", period_tick, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_ready", cfg_ready, 1'b1);
    chk("midrst_err", cfg_err, 1'b0);
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      hi += int'(clk_out) + int'(busy) + int'(period_tick);
    end
    chkv("midrst_no_n8_period", 32'(hi), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
